lfsr_4tap_chk: RTL and testbench

PRBS checker, the receive end of the 4-tap XNOR LFSR pattern generator used in the JTAG/link self-test path. Takes a serial bit stream with a valid strobe, locks onto the LFSR sequence without a seed, then free-runs a local copy. It reports lock status, per-bit error pulses and a saturating error count to the JTAG status registers.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_chk_cnt.sv | 36 +++
 rtl/lfsr_4tap_chk.sv | 154 +++++++++++++++
 tb/tb_lfsr_4tap_chk.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-tap XNOR LFSR generator/checker pair.
// No logic of its own; latency and backpressure do not apply.
// Holds the state encoding, default taps and the XNOR feedback function.
package lfsr_pkg;

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam int DEF_N    = 8;
    localparam int DEF_TAP1 = 4;
    localparam int DEF_TAP2 = 5;
    localparam int DEF_TAP3 = 6;

    // sr is zero-extended with register bit k at vector position k-1
    function automatic logic lfsr_fb(input logic [63:0] sr, input int n,
                                     input int t1, input int t2, input int t3);
        return ~(sr[6'(n - 1)] ^ sr[6'(t1 - 1)] ^ sr[6'(t2 - 1)] ^ sr[6'(t3 - 1)]);
    endfunction

endpackage

// File: rtl/lfsr_chk_cnt.sv
// Generic saturating up-counter with synchronous clear.
// Latency: count visible one cycle after inc; clear takes priority over inc.
// No backpressure: sticks at all-ones instead of wrapping.
module lfsr_chk_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_4tap_chk.sv
// PRBS checker for the 4-tap XNOR LFSR: seedless lock, flywheel, loss-of-sync.
// Latency: LOCKED/ERR_PULSE/ERR_CNT registered, one cycle after the DIN_VLD bit.
// No backpressure: every state change is gated by DIN_VLD. BIT_CNT needs LFSR_CHK_BER_EN.
module lfsr_4tap_chk
    import lfsr_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int FB_tap1  = DEF_TAP1,
    parameter int FB_tap2  = DEF_TAP2,
    parameter int FB_tap3  = DEF_TAP3,
    parameter int LOCK_CNT = 16,
    parameter int LOS_WIN  = 64,
    parameter int LOS_ERRS = 8,
    parameter int ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DIN,
    input  logic             DIN_VLD,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR_PULSE,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [31:0]      BIT_CNT
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOS_WIN + 1);
    localparam int WERR_W  = $clog2(LOS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   WIN_END    = WIN_W'(LOS_WIN);
    localparam logic [WERR_W-1:0]  WERR_LOS   = WERR_W'(LOS_ERRS);

    logic               state_q, state_d;
    logic [N:1]         sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               err_pulse_q, err_pulse_d;

    logic               pred;
    logic               mism;
    logic               sr_ones;
    logic [MATCH_W-1:0] match_inc;
    logic [WIN_W-1:0]   win_inc;
    logic [WERR_W-1:0]  werr_inc;

    assign pred      = lfsr_fb(64'(sr_q), N, FB_tap1, FB_tap2, FB_tap3);
    assign mism      = DIN_VLD && (DIN != pred);
    assign sr_ones   = &sr_q;
    assign match_inc = match_q + MATCH_W'(1);
    assign win_inc   = win_q + WIN_W'(1);
    assign werr_inc  = werr_q + WERR_W'(mism);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        if (DIN_VLD) begin
            if (state_q == ST_SEARCH) begin
                sr_d = {sr_q[N-1:1], DIN};
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + FILL_W'(1);
                end else if ((DIN == pred) && !sr_ones) begin
                    // all-ones is the XNOR lockup state: a stuck-at-1 line must never lock
                    if (match_inc == MATCH_LOCK) begin
                        state_d = ST_LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                sr_d        = {sr_q[N-1:1], pred};
                err_pulse_d = mism;
                if (werr_inc == WERR_LOS) begin
                    state_d = ST_SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                    win_d   = '0;
                    werr_d  = '0;
                end else if (win_inc == WIN_END) begin
                    win_d  = '0;
                    werr_d = '0;
                end else begin
                    win_d  = win_inc;
                    werr_d = werr_inc;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign LOCKED    = state_q;
    assign ERR_PULSE = err_pulse_q;

    logic err_inc;
    assign err_inc = (state_q == ST_LOCKED) && mism;

    lfsr_chk_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (CLR_CNT),
        .inc   (err_inc),
        .cnt   (ERR_CNT)
    );

`ifdef LFSR_CHK_BER_EN
    logic bit_inc;
    assign bit_inc = (state_q == ST_LOCKED) && DIN_VLD;

    lfsr_chk_cnt #(.W(32)) u_bit_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (CLR_CNT),
        .inc   (bit_inc),
        .cnt   (BIT_CNT)
    );
`else
    assign BIT_CNT = '0;
`endif

endmodule

// File: tb/tb_lfsr_4tap_chk.sv
// Scoreboarded bench for lfsr_4tap_chk: a driver feeds a reference generator stream
// and queues expected error pulses and lock transitions; a monitor pops and compares.
module tb_lfsr_4tap_chk;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        DIN = 1'b0;
    logic        DIN_VLD = 1'b0;
    logic        CLR_CNT = 1'b0;
    logic        LOCKED;
    logic        ERR_PULSE;
    logic [15:0] ERR_CNT;
    logic [31:0] BIT_CNT;

    always #5 CLK = ~CLK;

    lfsr_4tap_chk dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_VLD   (DIN_VLD),
        .CLR_CNT   (CLR_CNT),
        .LOCKED    (LOCKED),
        .ERR_PULSE (ERR_PULSE),
        .ERR_CNT   (ERR_CNT),
        .BIT_CNT   (BIT_CNT)
    );

    typedef struct {
        int   idx;
        logic val;
    } lock_ev_t;

    int       total = 0;
    int       bad = 0;
    int       issued = 0;
    int       vbits = 0;
    logic     vld_pend = 1'b0;
    logic     lock_prev = 1'b0;
    logic     push_en = 1'b1;
    logic     stuck = 1'b0;
    logic [8:1] gen_sr = '0;
    int       err_q[$];
    lock_ev_t lock_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic expect_lock(input int idx, input logic val);
        lock_ev_t e;
        e.idx = idx;
        e.val = val;
        lock_q.push_back(e);
    endtask

    // One cycle of stimulus; a valid bit comes from the reference generator (zero seed)
    task automatic drive(input logic v, input logic flip, input logic clr);
        logic gb;
        @(posedge CLK);
        #1;
        DIN_VLD = v;
        CLR_CNT = clr;
        if (v) begin
            if (stuck) begin
                DIN = 1'b1;
            end else begin
                gb     = ~(gen_sr[8] ^ gen_sr[4] ^ gen_sr[5] ^ gen_sr[6]);
                gen_sr = {gen_sr[7:1], gb};
                DIN    = gb ^ flip;
            end
            issued++;
            if (flip && push_en) err_q.push_back(issued);
        end else begin
            DIN = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N   = 1'b0;
        DIN_VLD = 1'b0;
        CLR_CNT = 1'b0;
        gen_sr  = '0;
        issued  = 0;
        stuck   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: vbits is the count of valid bits consumed since reset
    initial begin
        lock_ev_t e;
        int       exp_idx;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                vbits     = 0;
                vld_pend  = 1'b0;
                lock_prev = LOCKED;
                continue;
            end
            if (vld_pend) vbits++;
            if (ERR_PULSE) begin
                if (err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL err_pulse_unexpected: got pulse after bit %0d want none", vbits);
                end else begin
                    exp_idx = err_q.pop_front();
                    check("err_pulse_bit", 32'(vbits), 32'(exp_idx));
                end
            end
            if (LOCKED !== lock_prev) begin
                if (lock_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL lock_unexpected: got LOCKED=%0b at bit %0d want no change", LOCKED, vbits);
                end else begin
                    e = lock_q.pop_front();
                    check("lock_value", 32'(LOCKED), 32'(e.val));
                    check("lock_bit", 32'(vbits), 32'(e.idx));
                end
            end
            lock_prev = LOCKED;
            vld_pend  = DIN_VLD;
        end
    end

    initial begin
        int exp_bits;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_locked", 32'(LOCKED), 32'd0);
        check("rst_err_pulse", 32'(ERR_PULSE), 32'd0);
        check("rst_err_cnt", 32'(ERR_CNT), 32'd0);
        check("rst_bit_cnt", BIT_CNT, 32'd0);
        RST_N = 1'b1;

        // Clean stream: lock on the 24th valid bit, no errors over 1000 bits
        expect_lock(24, 1'b1);
        repeat (1000) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge CLK);
        check("clean_locked", 32'(LOCKED), 32'd1);
        check("clean_err_cnt", 32'(ERR_CNT), 32'd0);
`ifdef LFSR_CHK_BER_EN
        exp_bits = 976;
`else
        exp_bits = 0;
`endif
        check("clean_bit_cnt", BIT_CNT, 32'(exp_bits));

        // Three isolated errors, 100 bits apart
        for (int i = 1; i <= 320; i++) drive(1'b1, (i == 50 || i == 150 || i == 250), 1'b0);
        idle(3);
        @(negedge CLK);
        check("iso_err_cnt", 32'(ERR_CNT), 32'd3);
        check("iso_locked", 32'(LOCKED), 32'd1);

        // Eight errors at the start of a window force loss, then relock 24 bits later
        while (((issued - 24) % 64) != 0) drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 1'b0);
        expect_lock(issued, 1'b0);
        expect_lock(issued + 24, 1'b1);
        repeat (40) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge CLK);
        check("los_err_cnt", 32'(ERR_CNT), 32'd11);
        check("relock_locked", 32'(LOCKED), 32'd1);

        // Clear concurrent with an error: clear wins
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        idle(3);
        @(negedge CLK);
        check("clr_err_cnt", 32'(ERR_CNT), 32'd0);
        check("clr_bit_cnt", BIT_CNT, 32'd0);
        check("clr_locked", 32'(LOCKED), 32'd1);

        // Random valid gaps from reset
        idle(2);
        do_reset();
        expect_lock(24, 1'b1);
        while (issued < 300) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(3);
        @(negedge CLK);
        check("gap_locked", 32'(LOCKED), 32'd1);
        check("gap_err_cnt", 32'(ERR_CNT), 32'd0);
`ifdef LFSR_CHK_BER_EN
        exp_bits = 276;
`else
        exp_bits = 0;
`endif
        check("gap_bit_cnt", BIT_CNT, 32'(exp_bits));

        // Async reset while locked with an error pulse in flight
        push_en = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        @(posedge CLK);
        #2;
        check("pre_rst_pulse", 32'(ERR_PULSE), 32'd1);
        check("pre_rst_err_cnt", 32'(ERR_CNT), 32'd1);
        RST_N   = 1'b0;
        DIN_VLD = 1'b0;
        #1;
        check("arst_locked", 32'(LOCKED), 32'd0);
        check("arst_err_pulse", 32'(ERR_PULSE), 32'd0);
        check("arst_err_cnt", 32'(ERR_CNT), 32'd0);
        check("arst_bit_cnt", BIT_CNT, 32'd0);
        gen_sr  = '0;
        issued  = 0;
        push_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        expect_lock(24, 1'b1);
        repeat (40) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge CLK);
        check("arst_relock", 32'(LOCKED), 32'd1);

        // Stuck-at-1 line never locks
        do_reset();
        stuck = 1'b1;
        repeat (500) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge CLK);
        check("stuck_locked", 32'(LOCKED), 32'd0);
        check("stuck_err_cnt", 32'(ERR_CNT), 32'd0);
        stuck = 1'b0;

        idle(2);
        @(negedge CLK);
        check("lock_events_left", 32'(lock_q.size()), 32'd0);
        check("err_events_left", 32'(err_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
